// File: rtl/fft_seq_pkg.sv
// Shared definitions for the FFT frame sequencer: FSM state encoding and core config words.
package fft_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CFG     = 3'd1,
    CAPTURE = 3'd2,
    STREAM  = 3'd3,
    UNLOAD  = 3'd4,
    DONE    = 3'd5
  } seq_state_t;

  // Bit 0 is the core's fwd_inv flag: 1 = forward transform.
  localparam logic [7:0] CFG_FWD = 8'h01;
  localparam logic [7:0] CFG_INV = 8'h00;

  function automatic logic [7:0] cfg_word(input logic inverse);
    return inverse ? CFG_INV : CFG_FWD;
  endfunction

endpackage

// File: rtl/fft_frame_seq_if.sv
// Stream ports between the frame sequencer (master) and the transform core (slave).
interface fft_frame_seq_if #(
  parameter int SPEC_W = 16
);
  // Every channel: a beat transfers on a clock edge where valid && ready; once valid is
  // raised, data/last stay stable and valid stays high until that transfer happens.
  logic [7:0]          cfg_tdata;
  logic                cfg_tvalid;
  logic                cfg_tready;
  logic [2*SPEC_W-1:0] s_tdata;
  logic                s_tvalid;
  logic                s_tlast;
  logic                s_tready;
  logic [2*SPEC_W-1:0] m_tdata;
  logic                m_tvalid;
  logic                m_tlast;
  logic                m_tready;

  modport master (
    output cfg_tdata, cfg_tvalid, input cfg_tready,
    output s_tdata, s_tvalid, s_tlast, input s_tready,
    input  m_tdata, m_tvalid, m_tlast, output m_tready
  );

  modport slave (
    input  cfg_tdata, cfg_tvalid, output cfg_tready,
    input  s_tdata, s_tvalid, s_tlast, output s_tready,
    output m_tdata, m_tvalid, m_tlast, input m_tready
  );
endinterface

// File: rtl/fft_seq_buf.sv
// Sample frame buffer: simple dual-port RAM with a registered (1-cycle) read port.
module fft_seq_buf #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/fft_frame_seq.sv
// Frame sequencer: capture 2^N_LOG2 ADC samples, configure and feed the FFT core, unload to RAM.
// Define FFT_SEQ_AUTORUN_EN to loop DONE back to CAPTURE for continuous framing.
module fft_frame_seq
  import fft_seq_pkg::*;
#(
  parameter int N_LOG2 = 12,
  parameter int DATA_W = 10,
  parameter int SPEC_W = 16
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                start,
  input  logic                inverse,
  input  logic                smp_en,
  input  logic [DATA_W-1:0]   ad_data,
  fft_frame_seq_if.master     core,
  output logic                ram_we,
  output logic [N_LOG2-1:0]   ram_addr,
  output logic [SPEC_W-1:0]   ram_re,
  output logic [SPEC_W-1:0]   ram_im,
  output logic                busy,
  output logic                done,
  output logic                err,
  output seq_state_t          dbg_state
);
  localparam logic [N_LOG2-1:0] LAST_IDX = '1;
  localparam logic [N_LOG2-1:0] ONE      = 1;

  seq_state_t        state;
  logic [N_LOG2-1:0] wr_cnt, iss_cnt, rd_cnt;
  logic [7:0]        cfg_q;
  logic              cfg_vld, m_rdy;
  logic              iss_done, issue, pop, buf_we;
  logic [2:0]        occ_next;
  logic [DATA_W-1:0] buf_q;
  logic [SPEC_W-1:0] rd_re, out_re, sk_re;
  logic              rd_vld, rd_last, out_vld, out_last, sk_vld, sk_last;

  assign buf_we = (state == CAPTURE) && smp_en;

  fft_seq_buf #(.ADDR_W(N_LOG2), .DATA_W(DATA_W)) u_buf (
    .clk(sys_clk), .we(buf_we), .wr_addr(wr_cnt), .wr_data(ad_data),
    .rd_addr(iss_cnt), .rd_data(buf_q)
  );

  // Offset-binary to two's complement: flip the MSB, then sign-extend.
  assign rd_re = {{(SPEC_W-DATA_W+1){~buf_q[DATA_W-1]}}, buf_q[DATA_W-2:0]};

  // Items that will sit in out/skid after this edge; a new read lands one cycle later and
  // must find a free slot even if the core stalls, so only issue when at most one remains.
  assign pop      = out_vld && core.s_tready;
  assign occ_next = {2'b00, out_vld} + {2'b00, sk_vld} + {2'b00, rd_vld} - {2'b00, pop};
  assign issue    = (state == STREAM) && !iss_done && (occ_next <= 3'd1);

  assign core.s_tvalid   = out_vld;
  assign core.s_tlast    = out_last;
  assign core.s_tdata    = {{SPEC_W{1'b0}}, out_re};
  assign core.cfg_tdata  = cfg_q;
  assign core.cfg_tvalid = cfg_vld;
  assign core.m_tready   = m_rdy;
  assign dbg_state       = state;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      iss_cnt <= '0;  iss_done <= 1'b0;
      rd_vld  <= 1'b0; rd_last <= 1'b0;
      out_vld <= 1'b0; out_last <= 1'b0; out_re <= '0;
      sk_vld  <= 1'b0; sk_last  <= 1'b0; sk_re  <= '0;
    end else begin
      rd_vld  <= issue;
      rd_last <= issue && (iss_cnt == LAST_IDX);
      if (issue) begin
        iss_cnt <= iss_cnt + ONE;
        if (iss_cnt == LAST_IDX) iss_done <= 1'b1;
      end else if (state != STREAM) begin
        iss_done <= 1'b0;
      end
      // Oldest item in out, next in skid, newest on the buffer read port.
      if (pop || !out_vld) begin
        if (sk_vld) begin
          out_vld <= 1'b1;   out_last <= sk_last; out_re <= sk_re;
          sk_vld  <= rd_vld; sk_last  <= rd_last; sk_re  <= rd_re;
        end else begin
          out_vld <= rd_vld; out_last <= rd_last;
          if (rd_vld) out_re <= rd_re;
        end
      end else if (rd_vld) begin
        sk_vld <= 1'b1; sk_last <= rd_last; sk_re <= rd_re;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      wr_cnt   <= '0;  rd_cnt <= '0;
      cfg_q    <= '0;  cfg_vld <= 1'b0; m_rdy <= 1'b0;
      ram_we   <= 1'b0; ram_addr <= '0; ram_re <= '0; ram_im <= '0;
      busy     <= 1'b0; done <= 1'b0; err <= 1'b0;
    end else begin
      done   <= 1'b0;
      ram_we <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state   <= CFG;
          busy    <= 1'b1;
          err     <= 1'b0;
          cfg_q   <= cfg_word(inverse);
          cfg_vld <= 1'b1;
        end
        CFG: if (core.cfg_tready) begin
          cfg_vld <= 1'b0;
          state   <= CAPTURE;
        end
        CAPTURE: if (smp_en) begin
          wr_cnt <= wr_cnt + ONE;
          if (wr_cnt == LAST_IDX) state <= STREAM;
        end
        STREAM: if (pop && out_last) begin
          state  <= UNLOAD;
          rd_cnt <= '0;
          m_rdy  <= 1'b1;
        end
        UNLOAD: if (core.m_tvalid) begin
          ram_we   <= 1'b1;
          ram_addr <= rd_cnt;
          ram_re   <= core.m_tdata[SPEC_W-1:0];
          ram_im   <= core.m_tdata[2*SPEC_W-1:SPEC_W];
          rd_cnt   <= rd_cnt + ONE;
          if (core.m_tlast != (rd_cnt == LAST_IDX)) err <= 1'b1;
          if (core.m_tlast) begin
            m_rdy <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
`ifdef FFT_SEQ_AUTORUN_EN
          state <= CAPTURE;
`else
          state <= IDLE;
          busy  <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fft_frame_seq.sv
// Self-checking bench for fft_frame_seq (N_LOG2=4): random frames against a frame-level model.
module tb_fft_frame_seq;
  import fft_seq_pkg::*;

  localparam int N_LOG2 = 4;
  localparam int N      = 16;
  localparam int DATA_W = 10;
  localparam int SPEC_W = 16;
`ifdef FFT_SEQ_AUTORUN_EN
  localparam bit AUTORUN = 1'b1;
`else
  localparam bit AUTORUN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic sys_clk = 1'b0;
  logic sys_rst_n, start, inverse, smp_en;
  logic [DATA_W-1:0] ad_data;
  logic ram_we, busy, done, err;
  logic [N_LOG2-1:0] ram_addr;
  logic [SPEC_W-1:0] ram_re, ram_im;
  seq_state_t dbg_state;

  always #5 sys_clk = ~sys_clk;

  fft_frame_seq_if #(.SPEC_W(SPEC_W)) core ();

  fft_frame_seq #(.N_LOG2(N_LOG2), .DATA_W(DATA_W), .SPEC_W(SPEC_W)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .inverse(inverse),
    .smp_en(smp_en), .ad_data(ad_data), .core(core),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_re(ram_re), .ram_im(ram_im),
    .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int rmode   = 0;   // s_tready pattern: 0 always, 1 toggle, 2 random
  int done_cnt = 0;
  int cyc = 0;
  bit err_model = 1'b0;
  logic [32:0] s_exp_q[$];
  logic [35:0] ram_exp_q[$];
  logic [32:0] s_log[$];
  int          s_cyc_log[$];
  bit          s_stall_prev = 1'b0;
  logic [32:0] s_prev;
  bit          done_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // ---------------- compare process ----------------
  always @(negedge sys_clk) begin
    cyc++;
    if (sys_rst_n) begin
      if (s_stall_prev) begin
        check("s_hold_valid", core.s_tvalid, 1'b1);
        check("s_hold_data", {core.s_tlast, core.s_tdata}, s_prev);
      end
      if (core.s_tvalid && core.s_tready) begin
        s_log.push_back({core.s_tlast, core.s_tdata});
        s_cyc_log.push_back(cyc);
        if (s_exp_q.size() == 0) fail_now("s_extra_beat");
        else check("s_beat", {core.s_tlast, core.s_tdata}, s_exp_q.pop_front());
      end
      s_stall_prev = core.s_tvalid && !core.s_tready;
      s_prev = {core.s_tlast, core.s_tdata};
      if (ram_we) begin
        if (ram_exp_q.size() == 0) fail_now("ram_extra_write");
        else check("ram_write", {ram_addr, ram_im, ram_re}, ram_exp_q.pop_front());
      end
      if (done) begin
        done_cnt++;
        check("busy_at_done", busy, 1'b1);
        check("done_width", done_prev, 1'b0);
      end
      done_prev = done;
    end else begin
      s_stall_prev = 1'b0;
      done_prev = 1'b0;
    end
  end

  // ---------------- core-side s_tready driver ----------------
  always @(posedge sys_clk) begin
    #1;
    case (rmode)
      0:       core.s_tready = 1'b1;
      1:       core.s_tready = ~core.s_tready;
      default: core.s_tready = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- driver tasks (entered/left at posedge+1) ----------------
  task automatic run_frame(input bit do_start, input bit inv, input int cfg_dly,
                           input bit ramp, input int n_beats, input bit abort);
    logic [DATA_W-1:0] v;
    logic [SPEC_W-1:0] r16;
    logic [31:0] mdat;
    logic [3:0]  a;
    int r, done0, wc;
    bit hs, got;
    done0 = done_cnt;
    s_log.delete();
    s_cyc_log.delete();
    if (do_start) begin
      start = 1'b1; inverse = inv; smp_en = 1'b1; ad_data = 10'h3FF;
      @(posedge sys_clk); #1;
      start = 1'b0; inverse = 1'($urandom); err_model = 1'b0;
      for (int i = 0; i < cfg_dly; i++) begin
        smp_en = 1'b1; ad_data = 10'h3FF;
        @(negedge sys_clk);
        check("cfg_tvalid_held", core.cfg_tvalid, 1'b1);
        check("cfg_tdata", core.cfg_tdata, inv ? 8'h00 : 8'h01);
        @(posedge sys_clk); #1;
      end
      smp_en = 1'b0; core.cfg_tready = 1'b1;
      @(negedge sys_clk);
      check("cfg_tdata_hs", core.cfg_tdata, inv ? 8'h00 : 8'h01);
      @(posedge sys_clk); #1;
      core.cfg_tready = 1'b0;
      @(negedge sys_clk);
      check("cfg_tvalid_after_hs", core.cfg_tvalid, 1'b0);
      check("err_cleared", err, 1'b0);
      @(posedge sys_clk); #1;
    end
    for (int i = 0; i < N; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge sys_clk); #1; end
      v = ramp ? DATA_W'(i) : DATA_W'($urandom);
      r = int'(v) - 512;
      r16 = r[15:0];
      s_exp_q.push_back({(i == N - 1), 16'h0000, r16});
      smp_en = 1'b1; ad_data = v;
      @(posedge sys_clk); #1;
      smp_en = 1'b0; ad_data = 10'h3FF;
    end
    start = 1'b1; inverse = ~inv;
    @(posedge sys_clk); #1;
    start = 1'b0;
    @(negedge sys_clk);
    check("start_ignored_busy", core.cfg_tvalid, 1'b0);
    check("busy_stream", busy, 1'b1);
    @(posedge sys_clk); #1;
    if (abort) begin
      repeat (3) begin @(posedge sys_clk); #1; end
      @(negedge sys_clk);
      check("abort_pre_busy", busy, 1'b1);
      check("abort_pre_valid", core.s_tvalid, 1'b1);
      @(posedge sys_clk); #1;
      sys_rst_n = 1'b0;
      @(posedge sys_clk); #1;
      sys_rst_n = 1'b1;
      @(negedge sys_clk);
      check("rst_busy", busy, 1'b0);
      check("rst_s_tvalid", core.s_tvalid, 1'b0);
      check("rst_s_tdata", {core.s_tlast, core.s_tdata}, 33'h0);
      check("rst_cfg", {core.cfg_tvalid, core.cfg_tdata}, 9'h0);
      check("rst_m_tready", core.m_tready, 1'b0);
      check("rst_ram", {ram_we, ram_addr, ram_im, ram_re}, 37'h0);
      check("rst_flags", {done, err}, 2'b00);
      check("rst_state", dbg_state, IDLE);
      s_exp_q.delete();
      ram_exp_q.delete();
      err_model = 1'b0;
      @(posedge sys_clk); #1;
    end else begin
      for (int b = 0; b < n_beats; b++) begin
        if ($urandom_range(0, 3) == 0) begin @(posedge sys_clk); #1; end
        mdat = $urandom;
        a = b[3:0];
        if ((b == n_beats - 1) != ((b % N) == N - 1)) err_model = 1'b1;
        ram_exp_q.push_back({a, mdat});
        core.m_tvalid = 1'b1; core.m_tdata = mdat; core.m_tlast = (b == n_beats - 1);
        hs = 1'b0; wc = 0;
        while (!hs && wc < 300) begin
          @(negedge sys_clk); hs = core.m_tready;
          @(posedge sys_clk); #1; wc++;
        end
        core.m_tvalid = 1'b0; core.m_tlast = 1'b0;
        if (!hs) begin fail_now("m_handshake"); break; end
      end
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge sys_clk); #1;
        got = (done_cnt == done0 + 1);
      end
      if (!got) fail_now("done_pulse");
      check("err_flag", err, err_model);
      check("ram_queue_empty", ram_exp_q.size(), 0);
      check("s_queue_empty", s_exp_q.size(), 0);
      @(posedge sys_clk); #1;
      @(negedge sys_clk);
      check("busy_after_done", busy, AUTORUN);
      check("done_low", done, 1'b0);
      @(posedge sys_clk); #1;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    sys_rst_n = 1'b0; start = 1'b0; inverse = 1'b0; smp_en = 1'b0; ad_data = '0;
    core.cfg_tready = 1'b0; core.s_tready = 1'b1;
    core.m_tvalid = 1'b0; core.m_tlast = 1'b0; core.m_tdata = '0;
    repeat (3) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done_err", {done, err}, 2'b00);
    check("reset_cfg", {core.cfg_tvalid, core.cfg_tdata}, 9'h0);
    check("reset_s", {core.s_tvalid, core.s_tlast, core.s_tdata}, 34'h0);
    check("reset_m_tready", core.m_tready, 1'b0);
    check("reset_ram", {ram_we, ram_addr, ram_im, ram_re}, 37'h0);
    check("reset_state", dbg_state, IDLE);
    @(posedge sys_clk); #1;

    rmode = 0;
    run_frame(1'b1, 1'b1, 3, 1'b1, 16, 1'b0);
    if (s_log.size() == 16) begin
      check("pin_first_beat", s_log[0], 33'h0_0000_FE00);
      check("pin_last_beat", s_log[15], 33'h1_0000_FE0F);
      check("no_bubble", s_cyc_log[15] - s_cyc_log[0], 15);
    end else begin
      check("pin_beat_count", s_log.size(), 16);
    end

`ifdef FFT_SEQ_AUTORUN_EN
    rmode = 1;
    run_frame(1'b0, 1'b1, 0, 1'b0, 16, 1'b0);
    rmode = 2;
    run_frame(1'b0, 1'b1, 0, 1'b0, 16, 1'b0);
`else
    rmode = 1;
    run_frame(1'b1, 1'b0, 0, 1'b0, 16, 1'b0);
    rmode = 2;
    run_frame(1'b1, 1'b1, 1, 1'b0, 10, 1'b0);
    run_frame(1'b1, 1'b0, 2, 1'b0, 20, 1'b0);
    rmode = 1;
    run_frame(1'b1, 1'b0, 1, 1'b0, 16, 1'b1);
    rmode = 0;
    run_frame(1'b1, 1'b0, 1, 1'b0, 16, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    fail_now("global_timeout");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
